// File: rtl/operand_extend_pipe_if.sv
// Handshake bundle for operand_extend_pipe: operand input side, extended output
// side and the running accepted-operand count.
interface operand_extend_pipe_if #(
    parameter int OUT_W = 64,
    parameter int CNT_W = 16
);
    logic [OUT_W-1:0] X;
    logic [1:0]       Prec;
    logic             Signed;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] Y;
    logic [1:0]       Y_prec;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] accepted;

    // Producer/consumer side that drives operands and accepts results.
    modport master (
        output X, Prec, Signed, in_valid, out_ready,
        input  in_ready, Y, Y_prec, out_valid, accepted
    );

    // The extension pipe itself.
    modport slave (
        input  X, Prec, Signed, in_valid, out_ready,
        output in_ready, Y, Y_prec, out_valid, accepted
    );
endinterface

// File: rtl/operand_extend_pipe.sv
// Sign/zero-extends a right-aligned operand of selectable precision to OUT_W bits
// and buffers the result with its precision tag in a 2-entry FIFO.
module operand_extend_pipe #(
    parameter int OUT_W = 64,
    parameter int W0    = 8,
    parameter int W1    = 16,
    parameter int W2    = 32,
    parameter int W3    = 48,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_extend_pipe_if.slave bus
);
    localparam int ENT_W = OUT_W + 2;

    logic [OUT_W-1:0] ext_cand [4];
    logic [ENT_W-1:0] new_entry;

    logic [ENT_W-1:0] head_reg,     head_next;
    logic [ENT_W-1:0] tail_reg,     tail_next;
    logic [1:0]       count_reg,    count_next;
    logic [CNT_W-1:0] accepted_reg, accepted_next;

    logic in_ready_int;
    logic out_valid_int;
    logic push;
    logic pop;

    // One extension candidate per selectable precision; Prec picks among them.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ext
            localparam int WG = (gi == 0) ? W0 : (gi == 1) ? W1 : (gi == 2) ? W2 : W3;
            if (WG >= OUT_W) begin : g_full
                assign ext_cand[gi] = bus.X;
            end else begin : g_part
                assign ext_cand[gi] = {{(OUT_W - WG){bus.Signed & bus.X[WG-1]}}, bus.X[WG-1:0]};
            end
        end
    endgenerate

    assign new_entry = {bus.Prec, ext_cand[bus.Prec]};

    // Readiness comes purely from registered occupancy, never from out_ready.
    assign in_ready_int  = (count_reg != 2'd2);
    assign out_valid_int = (count_reg != 2'd0);
    assign push          = bus.in_valid & in_ready_int;
    assign pop           = out_valid_int & bus.out_ready;

    always_comb begin
        head_next     = head_reg;
        tail_next     = tail_reg;
        count_next    = count_reg;
        accepted_next = push ? accepted_reg + CNT_W'(1) : accepted_reg;
        case (count_reg)
            2'd0: begin
                if (push) begin
                    head_next  = new_entry;
                    count_next = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_next = new_entry;
                end else if (push) begin
                    tail_next  = new_entry;
                    count_next = 2'd2;
                end else if (pop) begin
                    // Head keeps its last value so Y never goes unknown when empty.
                    count_next = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_next  = tail_reg;
                    count_next = 2'd1;
                end
            end
            default: begin
                count_next = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= 2'd0;
            accepted_reg <= '0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            accepted_reg <= accepted_next;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.Y         = head_reg[OUT_W-1:0];
    assign bus.Y_prec    = head_reg[ENT_W-1:OUT_W];
    assign bus.accepted  = accepted_reg;
endmodule

// File: tb/tb_operand_extend_pipe.sv
// Randomized and directed bench for operand_extend_pipe against an arithmetic
// reference model with a queue standing in for the FIFO.
module tb_operand_extend_pipe;
    localparam int OUT_W = 64;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    operand_extend_pipe_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    operand_extend_pipe #(
        .OUT_W(OUT_W), .W0(8), .W1(16), .W2(32), .W3(48), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          acc_cnt = 0;
    int          widths [4] = '{8, 16, 32, 48};
    logic [65:0] model_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference extension: reduce modulo 2^w, then reinterpret as signed if asked.
    function automatic logic [63:0] ref_ext(input logic [63:0] x, input int w, input logic s);
        logic [127:0] lim;
        logic [127:0] lo;
        lim = 128'd1 << w;
        lo  = {64'd0, x} % lim;
        if (s && lo >= (lim >> 1))
            lo = lo - lim;
        return lo[63:0];
    endfunction

    task automatic check_state();
        check("out_valid", {63'd0, bus.out_valid}, {63'd0, model_q.size() > 0});
        check("in_ready", {63'd0, bus.in_ready}, {63'd0, model_q.size() < 2});
        check("accepted", {60'd0, bus.accepted}, 64'(acc_cnt % 16));
        if (model_q.size() > 0) begin
            check("y", bus.Y, model_q[0][63:0]);
            check("y_prec", {62'd0, bus.Y_prec}, {62'd0, model_q[0][65:64]});
        end
    endtask

    // Call at posedge+1; returns at the following posedge+1.
    task automatic step(input logic iv, input logic [63:0] x, input logic [1:0] p,
                        input logic s, input logic ordy);
        bit do_push;
        bit do_pop;
        bus.in_valid  = iv;
        bus.X         = x;
        bus.Prec      = p;
        bus.Signed    = s;
        bus.out_ready = ordy;
        @(negedge clk);
        check_state();
        do_push = iv && (model_q.size() < 2);
        do_pop  = ordy && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop)
            void'(model_q.pop_front());
        if (do_push) begin
            model_q.push_back({p, ref_ext(x, widths[p], s)});
            acc_cnt++;
        end
        $display("txn t=%0t push=%0d pop=%0d x=0x%016h prec=%0d signed=%0d occ=%0d acc=%0d",
                 $time, do_push, do_pop, x, p, s, model_q.size(), acc_cnt % 16);
    endtask

    initial begin
        logic [63:0] op1;
        int          base;
        bus.in_valid  = 1'b0;
        bus.X         = '0;
        bus.Prec      = 2'd0;
        bus.Signed    = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_y", bus.Y, 64'd0);
        check("rst_y_prec", {62'd0, bus.Y_prec}, 64'd0);
        check("rst_accepted", {60'd0, bus.accepted}, 64'd0);
        rst = 1'b0;

        // Sign-extend a 16-bit operand into an empty FIFO: visible one edge later.
        step(1'b1, 64'h0000_0000_0000_8001, 2'd1, 1'b1, 1'b1);
        check("req032_y", bus.Y, 64'hFFFF_FFFF_FFFF_8001);
        check("req032_y_prec", {62'd0, bus.Y_prec}, 64'd1);
        check("req032_accepted", {60'd0, bus.accepted}, 64'd1);
        check("req032_valid", {63'd0, bus.out_valid}, 64'd1);
        step(1'b0, 64'd0, 2'd0, 1'b0, 1'b1);

        // 48-bit zero then sign extension; the second push pops the first.
        step(1'b1, 64'hABCD_8000_0000_0001, 2'd3, 1'b0, 1'b1);
        check("req033_zext", bus.Y, 64'h0000_8000_0000_0001);
        base = acc_cnt;
        step(1'b1, 64'hABCD_8000_0000_0001, 2'd3, 1'b1, 1'b1);
        check("req033_sext", bus.Y, 64'hFFFF_8000_0000_0001);
        check("req035_valid", {63'd0, bus.out_valid}, 64'd1);
        check("req035_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("req035_accepted", {60'd0, bus.accepted}, 64'((base + 1) % 16));
        step(1'b0, 64'd0, 2'd0, 1'b0, 1'b1);

        // Three back-to-back pushes with a stalled consumer.
        base = acc_cnt;
        op1  = 64'h0000_0000_0000_00F0;
        step(1'b1, op1, 2'd0, 1'b1, 1'b0);
        step(1'b1, 64'h0000_0000_1234_5678, 2'd2, 1'b0, 1'b0);
        check("req034_in_ready", {63'd0, bus.in_ready}, 64'd0);
        step(1'b1, 64'h0000_0000_0000_7777, 2'd1, 1'b0, 1'b0);
        check("req034_accepted", {60'd0, bus.accepted}, 64'((base + 2) % 16));
        check("req034_y_hold", bus.Y, 64'hFFFF_FFFF_FFFF_FFF0);

        // Asynchronous reset while full, between edges.
        #2 rst = 1'b1;
        #1;
        check("req036_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("req036_accepted", {60'd0, bus.accepted}, 64'd0);
        check("req036_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("req036_y", bus.Y, 64'd0);
        model_q.delete();
        acc_cnt = 0;
        rst = 1'b0;

        // Seventeen pushes from reset wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++)
            step(1'b1, {$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'($urandom), 1'b1);
        check("req037_accepted", {60'd0, bus.accepted}, 64'd1);
        step(1'b0, 64'd0, 2'd0, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
                 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 3; i++)
            step(1'b0, 64'd0, 2'd0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/operand_extend_pipe.md
OPERAND_EXTEND_PIPE -- requirements
Module: operand_extend_pipe

Interface
REQ-001 Parameter OUT_W, default 64: output operand width in bits.
REQ-002 Parameters W0, W1, W2, W3, defaults 8, 16, 32, 48: the selectable source precisions; legal set is 1 <= W0 < W1 < W2 < W3 <= OUT_W.
REQ-003 Parameter CNT_W, default 16: width of the accepted-operand counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 X  input  OUT_W  source operand, right-aligned; bits above the selected precision are ignored.
REQ-007 Prec  input  2  precision select: 0->W0, 1->W1, 2->W2, 3->W3.
REQ-008 Signed  input  1  1 = sign-extend, 0 = zero-extend.
REQ-009 in_valid  input  1  X/Prec/Signed valid this cycle.
REQ-010 in_ready  output  1  block can accept an operand this cycle.
REQ-011 Y  output  OUT_W  extended operand at FIFO head.
REQ-012 Y_prec  output  2  Prec tag travelling with Y.
REQ-013 out_valid  output  1  Y/Y_prec valid.
REQ-014 out_ready  input  1  downstream accepts Y this cycle.
REQ-015 accepted  output  CNT_W  running count of accepted operands.

Function
REQ-016 A push occurs on a rising edge with in_valid=1 and in_ready=1; a pop occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-017 Extension is computed combinationally at the input and stored at push: with W the selected precision, Y[W-1:0] = X[W-1:0], and Y[OUT_W-1:W] = all X[W-1] if Signed=1, else all 0.
REQ-018 When W equals OUT_W, Y equals X for both Signed values.
REQ-019 Storage is a 2-entry FIFO holding {Y, Y_prec}; occupancy is 0, 1 or 2.
REQ-020 in_ready = 1 when occupancy < 2; it depends only on registered occupancy, with no combinational path from out_ready.
REQ-021 out_valid = 1 when occupancy > 0; Y and Y_prec always show the oldest entry.
REQ-022 Latency: an operand pushed at edge N into an empty FIFO is visible with out_valid=1 immediately after edge N.
REQ-023 Simultaneous push and pop at occupancy 1: occupancy stays 1, the new entry becomes head after the edge, and order is preserved.
REQ-024 Simultaneous push and pop at occupancy 2 cannot occur because in_ready=0; a pop alone moves occupancy to 1.
REQ-025 A pop at occupancy 0 is impossible because out_valid=0; out_ready is ignored when empty.
REQ-026 Y and Y_prec hold their value while out_valid=1 and out_ready=0 (no change without a pop).
REQ-027 accepted increments by 1 on every push and wraps from 2^CNT_W-1 to 0.
REQ-028 When out_valid=0, Y and Y_prec are don't-care, but the RTL shall not produce X-propagation (drive the last-written or reset value).

Reset
REQ-029 On rst=1 asynchronously: occupancy is 0, out_valid is 0, in_ready is 1, Y is 0, Y_prec is 0, and accepted is 0.
REQ-030 Reset asserted mid-transfer discards all stored entries; no pop or push is counted on an edge where rst=1.
REQ-031 After rst deasserts, the first rising edge can accept a push.

Verification
REQ-032 Prec=1, Signed=1, X=0x...00008001, out_ready=1 -> one edge later Y=0xFFFFFFFFFFFF8001, Y_prec=1, accepted=1.
REQ-033 Prec=3, Signed=0, X=0xABCD_8000_0000_0001 -> Y=0x0000_8000_0000_0001; the same X with Signed=1 -> Y=0xFFFF_8000_0000_0001.
REQ-034 out_ready=0, push 3 operands on back-to-back cycles -> in_ready=0 after the 2nd push, the 3rd operand is not accepted, accepted=2, and Y holds operand 1.
REQ-035 Occupancy 1 with push and pop in the same cycle -> occupancy stays 1, Y = the newly pushed value, and accepted increments by 1.
REQ-036 Occupancy 2, rst pulsed between edges -> out_valid=0 and accepted=0 immediately, with no edge required.
REQ-037 CNT_W=4: push 17 operands -> accepted=1 after wrap, with data order intact.
